// File: rtl/hazard_stall_ctrl.sv
// Load-use / ID-branch hazard detection and stall control for the ID stage.
// Optional stall-cycle counter is built when HAZARD_STALL_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       id_instr,
  input  logic              idex_mem_read,
  input  logic              idex_reg_write,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              exmem_mem_read,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ctrl_sel,
  output logic              ifid_flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t            state;
  logic [2:0]        hold_cnt;
  logic [5:0]        op;
  logic [REG_AW-1:0] rs, rt;
  logic              use_rs, use_rt, is_br;
  logic              hit_idex, hit_exmem;
  logic              load_use, br_haz, stall, stall_eff;
  logic              unused_ok;

  assign op = id_instr[31:26];
  assign rs = REG_AW'(id_instr[25:21]);
  assign rt = REG_AW'(id_instr[20:16]);
  assign unused_ok = ^id_instr[15:0];

  // rt is a destination for I-type ALU ops and loads, so only a few opcodes read it
  assign use_rs = !(op == 6'h02 || op == 6'h03 || op == 6'h0F);
  assign use_rt = (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B);
  assign is_br  = (op == 6'h04 || op == 6'h05);

  assign hit_idex  = (idex_rd != '0) &&
                     ((use_rs && rs == idex_rd) || (use_rt && rt == idex_rd));
  assign hit_exmem = (exmem_rd != '0) &&
                     ((use_rs && rs == exmem_rd) || (use_rt && rt == exmem_rd));

  assign load_use = idex_mem_read && hit_idex;
  assign br_haz   = is_br && ((idex_reg_write && hit_idex) ||
                              (exmem_mem_read && hit_exmem));

  assign stall     = (state == HOLD) || load_use || br_haz;
  assign stall_eff = rst_n && stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      hold_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (load_use && LOAD_LAT > 1) begin
            state    <= HOLD;
            hold_cnt <= 3'(LOAD_LAT - 1);
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 3'd1;
          if (hold_cnt == 3'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // A stall masks branch_taken: branch operands are not valid yet
  assign pc_write   = !stall_eff;
  assign ifid_write = !stall_eff;
  assign ctrl_sel   = !stall_eff;
  assign ifid_flush = rst_n && !stall && branch_taken;

`ifdef HAZARD_STALL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (stall && cnt != '1)    cnt <= cnt + 1'b1;
  end

  assign stall_cnt = cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl; three instances cover LOAD_LAT = 1, 3, 4.
module tb_hazard_stall_ctrl;

`ifdef HAZARD_STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [3:0] O_RUN   = 4'b1110;
  localparam logic [3:0] O_STALL = 4'b0000;
  localparam logic [3:0] O_FLUSH = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        idex_mem_read, idex_reg_write, exmem_mem_read, branch_taken;
  logic [4:0]  idex_rd, exmem_rd;

  logic        pw1, iw1, cs1, fl1;
  logic        pw3, iw3, cs3, fl3;
  logic        pw4, iw4, cs4, fl4;
  logic [1:0]  cnt1;
  logic [15:0] cnt3, cnt4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr),
    .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_rd(idex_rd),
    .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd), .branch_taken(branch_taken),
    .pc_write(pw1), .ifid_write(iw1), .ctrl_sel(cs1), .ifid_flush(fl1), .stall_cnt(cnt1));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr),
    .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_rd(idex_rd),
    .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd), .branch_taken(branch_taken),
    .pc_write(pw3), .ifid_write(iw3), .ctrl_sel(cs3), .ifid_flush(fl3), .stall_cnt(cnt3));

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(4), .CNT_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr),
    .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_rd(idex_rd),
    .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd), .branch_taken(branch_taken),
    .pc_write(pw4), .ifid_write(iw4), .ctrl_sel(cs4), .ifid_flush(fl4), .stall_cnt(cnt4));

  logic [3:0] o1, o3, o4;
  assign o1 = {pw1, iw1, cs1, fl1};
  assign o3 = {pw3, iw3, cs3, fl3};
  assign o4 = {pw4, iw4, cs4, fl4};

  // Instruction encodings
  localparam logic [31:0] ADD_9_8_10 = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] ADD_1_0_0  = {6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20};
  localparam logic [31:0] LUI_RS5    = {6'h0F, 5'd5, 5'd6, 16'h1234};
  localparam logic [31:0] ADDI_5_3   = {6'h08, 5'd3, 5'd5, 16'd1};
  localparam logic [31:0] BEQ_4_5    = {6'h04, 5'd4, 5'd5, 16'h0010};
  localparam logic [31:0] BEQ_1_2    = {6'h04, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] SW_7_2     = {6'h2B, 5'd2, 5'd7, 16'd0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_instr       = 32'h0;
    idex_mem_read  = 1'b0;
    idex_reg_write = 1'b0;
    idex_rd        = 5'd0;
    exmem_mem_read = 1'b0;
    exmem_rd       = 5'd0;
    branch_taken   = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    // Hazard and taken branch present during reset: outputs stay forced
    id_instr = ADD_9_8_10; idex_mem_read = 1'b1; idex_rd = 5'd8; branch_taken = 1'b1;
    #1;
    chk("rst_out_u1", 32'(o1), 32'(O_RUN));
    chk("rst_out_u4", 32'(o4), 32'(O_RUN));
    chk("rst_cnt", 32'(cnt3), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs, LOAD_LAT=1
    cyc(); id_instr = ADD_9_8_10; idex_mem_read = 1'b1; idex_rd = 5'd8;
    @(negedge clk); chk("lu_rs_stall", 32'(o1), 32'(O_STALL));
    cyc(); id_instr = ADD_9_8_10; exmem_mem_read = 1'b1; exmem_rd = 5'd8;
    @(negedge clk); chk("lu_rs_after", 32'(o1), 32'(O_RUN));
    chk("lu_rs_cnt", 32'(cnt1), PERF ? 32'd1 : 32'd0);

    // False hazards
    cyc(); id_instr = ADD_1_0_0; idex_mem_read = 1'b1; idex_rd = 5'd0;
    @(negedge clk); chk("fh_r0", 32'(o1), 32'(O_RUN));
    cyc(); id_instr = LUI_RS5; idex_mem_read = 1'b1; idex_rd = 5'd5;
    @(negedge clk); chk("fh_lui", 32'(o1), 32'(O_RUN));
    cyc(); id_instr = ADDI_5_3; idex_mem_read = 1'b1; idex_rd = 5'd5;
    @(negedge clk); chk("fh_addi_rt", 32'(o1), 32'(O_RUN));

    // Load feeding BEQ: stall via ID/EX, then via EX/MEM, then taken flush
    cyc(); id_instr = BEQ_4_5; idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 5'd4;
    @(negedge clk); chk("ldbr_c1", 32'(o1), 32'(O_STALL));
    cyc(); id_instr = BEQ_4_5; exmem_mem_read = 1'b1; exmem_rd = 5'd4; branch_taken = 1'b1;
    @(negedge clk); chk("ldbr_c2", 32'(o1), 32'(O_STALL));
    cyc(); id_instr = BEQ_4_5; branch_taken = 1'b1;
    @(negedge clk); chk("ldbr_c3", 32'(o1), 32'(O_FLUSH));
    cyc();
    @(negedge clk); chk("ldbr_c4", 32'(o1), 32'(O_RUN));

    // Taken branch with unrelated producer
    cyc(); id_instr = BEQ_1_2; idex_reg_write = 1'b1; idex_rd = 5'd3; branch_taken = 1'b1;
    @(negedge clk); chk("br_taken", 32'(o1), 32'(O_FLUSH));

    // Load-use on rt, pushes 2-bit counter past its top
    cyc(); id_instr = ADD_9_8_10; idex_mem_read = 1'b1; idex_rd = 5'd10;
    @(negedge clk); chk("lu_rt_stall", 32'(o1), 32'(O_STALL));
    cyc();
    @(negedge clk); chk("lu_rt_after", 32'(o1), 32'(O_RUN));
    chk("cnt_sat", 32'(cnt1), PERF ? 32'd3 : 32'd0);

    // LOAD_LAT=3 hold on SW rt
    do_rst();
    cyc(); id_instr = SW_7_2; idex_mem_read = 1'b1; idex_rd = 5'd7;
    @(negedge clk); chk("hold3_c1", 32'(o3), 32'(O_STALL));
    cyc(); id_instr = SW_7_2;
    @(negedge clk); chk("hold3_c2", 32'(o3), 32'(O_STALL));
    cyc(); id_instr = SW_7_2;
    @(negedge clk); chk("hold3_c3", 32'(o3), 32'(O_STALL));
    cyc(); id_instr = SW_7_2;
    @(negedge clk); chk("hold3_done", 32'(o3), 32'(O_RUN));
    chk("hold3_cnt", 32'(cnt3), PERF ? 32'd3 : 32'd0);

    // ALU producer into branch: single-cycle stall, no HOLD even with LOAD_LAT=3
    cyc(); id_instr = BEQ_4_5; idex_reg_write = 1'b1; idex_rd = 5'd5;
    @(negedge clk); chk("alubr_c1", 32'(o3), 32'(O_STALL));
    cyc(); id_instr = BEQ_4_5;
    @(negedge clk); chk("alubr_c2", 32'(o3), 32'(O_RUN));

    // LOAD_LAT=4, reset in the 2nd stall cycle
    do_rst();
    cyc(); id_instr = ADD_9_8_10; idex_mem_read = 1'b1; idex_rd = 5'd8;
    @(negedge clk); chk("hold4_c1", 32'(o4), 32'(O_STALL));
    cyc(); id_instr = ADD_9_8_10;
    @(negedge clk); chk("hold4_c2", 32'(o4), 32'(O_STALL));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(o4), 32'(O_RUN));
    chk("midrst_cnt", 32'(cnt4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); id_instr = ADD_9_8_10;
      @(negedge clk); chk($sformatf("postrst_%0d", i), 32'(o4), 32'(O_RUN));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised hazard detection and stall controller for the 5-stage pipeline, sitting in the ID stage beside the register file. It decodes which source registers the ID instruction actually reads. It detects load-use hazards and ID-resolved branch hazards, and holds the pipeline for a configurable number of load-latency cycles. It also flushes IF/ID on a taken branch, and can optionally count stall cycles.

## Interface
- `REG_AW`, 5: register-index width.
- `LOAD_LAT`, 1: bubbles inserted per load-use hazard; legal range 1..4.
- `CNT_W`, 16: stall-counter width.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_instr`  in  32  instruction in IF/ID.
- `idex_mem_read`  in  1  instruction in ID/EX is a load.
- `idex_reg_write`  in  1  instruction in ID/EX writes a register.
- `idex_rd`  in  REG_AW  destination of the ID/EX instruction, after the rt/rd mux.
- `exmem_mem_read`  in  1  instruction in EX/MEM is a load.
- `exmem_rd`  in  REG_AW  destination of the EX/MEM instruction.
- `branch_taken`  in  1  branch in ID resolved taken this cycle.
- `pc_write`  out  1  1 = PC updates.
- `ifid_write`  out  1  1 = IF/ID updates.
- `ctrl_sel`  out  1  1 = pass decoded control into ID/EX; 0 = insert bubble (all-zero control).
- `ifid_flush`  out  1  1 = clear IF/ID to NOP at next edge.
- `stall_cnt`  out  CNT_W  total stall cycles since reset.

## Operation
- Fields: `rs = id_instr[25:21]`, `rt = id_instr[20:16]`, `op = id_instr[31:26]`.
- `use_rs` is 1 except for op 0x02 (J), 0x03 (JAL) and 0x0F (LUI).
- `use_rt` is 1 for op 0x00 (R-type), 0x04 (BEQ), 0x05 (BNE) and 0x2B (SW); 0 otherwise.
- A source matches register r when its use bit is set, r != 0, and the field equals r.
- `load_use` = `idex_mem_read` and (rs or rt matches `idex_rd`).
- `br_haz` applies only when op is 0x04 or 0x05. It is set when (`idex_reg_write` and a source matches `idex_rd`) or (`exmem_mem_read` and a source matches `exmem_rd`).
- FSM states:
  - RUN: `stall = load_use | br_haz`. If `load_use` and `LOAD_LAT` > 1, go to HOLD with `hold_cnt = LOAD_LAT-1`.
  - HOLD: `stall = 1` unconditionally and `hold_cnt` decrements each cycle. When `hold_cnt == 1`, the next state is RUN.
- Outputs:
  - While stalling: `pc_write = 0`, `ifid_write = 0`, `ctrl_sel = 0`, `ifid_flush = 0`.
  - While not stalling: `pc_write = 1`, `ifid_write = 1`, `ctrl_sel = 1`, `ifid_flush = branch_taken`.
- `branch_taken` is ignored while stalling, because branch operands are not yet valid. The stall always wins over the flush.
- A `br_haz` stall never enters HOLD. It re-evaluates each cycle as the producer advances, so a load feeding a branch stalls 2 cycles when `LOAD_LAT` = 1.

## Timing
- Hazard and output logic is combinational from the inputs and the FSM state, with no same-cycle latency.
- FSM state, `hold_cnt` and `stall_cnt` update on the rising edge of `clk`.
- A load-use hazard stalls exactly `LOAD_LAT` consecutive cycles, starting in the detection cycle.
- Reset is asynchronous on `rst_n` low: state goes to RUN, `hold_cnt` to 0 and `stall_cnt` to 0.
- While `rst_n` is low, outputs are forced to `pc_write = 1`, `ifid_write = 1`, `ctrl_sel = 1`, `ifid_flush = 0`.
- Reset asserted during HOLD aborts the hold immediately. After release, the block is in RUN with no residual stall.
- `stall_cnt` increments in every cycle where `stall = 1` and saturates at all-ones; it does not wrap.

## Configuration
- The macro is `HAZARD_STALL_PERF_CNT_EN`.
- When defined: the `stall_cnt` register and incrementer are built as described above.
- When undefined: no counter is built and `stall_cnt` is tied to 0.
- All other behaviour is identical either way.

## Test plan
- Load-use on rs: `idex_mem_read = 1`, `idex_rd = 8`, `id_instr` = ADD $9,$8,$10, `LOAD_LAT = 1`.
  - Required: `pc_write = ifid_write = ctrl_sel = 0` for 1 cycle, then all 1.
  - With `HAZARD_STALL_PERF_CNT_EN` defined, `stall_cnt` = 1.
- False-hazard filter, two cases, each with no stall and all outputs at 1:
  - `idex_mem_read = 1`, `idex_rd = 0`, instruction reads $0.
  - LUI with `rs` field = `idex_rd` = 5.
- Multi-cycle hold: `LOAD_LAT = 3`, load-use on rt of SW. Required: exactly 3 stall cycles, then RUN.
- Load feeding BEQ: LW $4 followed by BEQ $4,$5.
  - Required: 2 stall cycles (first via ID/EX, then via EX/MEM), no flush.
  - `branch_taken = 1` in cycle 3 gives `ifid_flush = 1` for 1 cycle.
- Taken branch without hazard: `branch_taken = 1`. Required: `ifid_flush = 1`, `pc_write = 1`.
- Reset mid-hold: `LOAD_LAT = 4`, drop `rst_n` in the 2nd stall cycle.
  - Required: outputs go to 1 immediately and `stall_cnt` = 0.
  - After release, no stall while the inputs carry no hazard.
